// File: rtl/zaman_alani_sayaci.sv
// One field of a clock/calendar (hour, minute, second, day, month): wrap-around
// counter with load, runtime upper bound, chained carry/borrow and button auto-repeat.
module zaman_alani_sayaci #(
  parameter int WIDTH        = 6,
  parameter int MIN_VAL      = 0,
  parameter int RESET_VAL    = 18,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stop,
  input  logic             arttir_buton,
  input  logic             azalt_buton,
  input  logic             carry_in,
  input  logic             borrow_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] value,
  output logic             carry_out,
  output logic             borrow_out
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [WIDTH-1:0] MIN_V      = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] RESET_V    = WIDTH'(RESET_VAL);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {LOCKED, IDLE, DELAY, REPEAT} btn_state_t;

  btn_state_t       btn_state;
  logic [CNT_W-1:0] rep_cnt;
  logic             dir_up;

  logic             both_pressed;
  logic             held;
  logic             btn_step;
  logic             step_dir_up;
  logic             step_up;
  logic             step_down;
  logic [WIDTH-1:0] load_clamped;

  assign both_pressed = arttir_buton && azalt_buton;
  assign held         = dir_up ? arttir_buton : azalt_buton;
  assign step_dir_up  = (btn_state == IDLE) ? arttir_buton : dir_up;

  // The step pulse is decoded from the current state so a press shows up after one edge.
  always_comb begin
    btn_step = 1'b0;
    case (btn_state)
      IDLE:    btn_step = arttir_buton ^ azalt_buton;
      DELAY:   btn_step = !both_pressed && held && (rep_cnt == DELAY_LAST);
      REPEAT:  btn_step = !both_pressed && held && (rep_cnt == RATE_LAST);
      default: btn_step = 1'b0;
    endcase
  end

  assign step_up   = stop ? (btn_step && step_dir_up)  : (carry_in && !borrow_in);
  assign step_down = stop ? (btn_step && !step_dir_up) : (borrow_in && !carry_in);

  assign load_clamped = (load_val <= MIN_V)  ? MIN_V   :
                        (load_val > max_val) ? max_val : load_val;

  // LOCKED waits for both buttons to be released, so a press held across reset or
  // across leaving edit mode never produces a step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_state <= LOCKED;
      rep_cnt   <= '0;
      dir_up    <= 1'b0;
    end else if (!stop) begin
      btn_state <= LOCKED;
      rep_cnt   <= '0;
    end else begin
      case (btn_state)
        LOCKED: begin
          rep_cnt <= '0;
          if (!arttir_buton && !azalt_buton) btn_state <= IDLE;
        end
        IDLE: begin
          rep_cnt <= '0;
          if (both_pressed) begin
            btn_state <= LOCKED;
          end else if (arttir_buton || azalt_buton) begin
            btn_state <= DELAY;
            dir_up    <= arttir_buton;
          end
        end
        DELAY: begin
          if (both_pressed) begin
            btn_state <= LOCKED;
            rep_cnt   <= '0;
          end else if (!held) begin
            btn_state <= IDLE;
            rep_cnt   <= '0;
          end else if (rep_cnt == DELAY_LAST) begin
            btn_state <= REPEAT;
            rep_cnt   <= '0;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (both_pressed) begin
            btn_state <= LOCKED;
            rep_cnt   <= '0;
          end else if (!held) begin
            btn_state <= IDLE;
            rep_cnt   <= '0;
          end else if (rep_cnt == RATE_LAST) begin
            rep_cnt <= '0;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
        default: begin
          btn_state <= LOCKED;
          rep_cnt   <= '0;
        end
      endcase
    end
  end

  // Load beats the bound clamp, which beats stepping; a shrinking bound swallows any step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value      <= RESET_V;
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
    end else begin
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
      if (load) begin
        value <= load_clamped;
      end else if (value > max_val) begin
        value <= max_val;
      end else if (step_up) begin
        if (value >= max_val) begin
          value     <= MIN_V;
          carry_out <= 1'b1;
        end else begin
          value <= value + 1'b1;
        end
      end else if (step_down) begin
        if (value <= MIN_V) begin
          value      <= max_val;
          borrow_out <= 1'b1;
        end else begin
          value <= value - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_zaman_alani_sayaci.sv
// Directed bench: an hour-style field (0..23, reset 18) and a day-style field
// (MIN_VAL 1, reset 31) driven with hand-computed sequences.
module tb_zaman_alani_sayaci;

  logic       clk;
  logic       reset;

  logic       h_stop, h_up_btn, h_down_btn, h_carry_in, h_borrow_in, h_load;
  logic [5:0] h_load_val, h_max_val, h_value;
  logic       h_carry_out, h_borrow_out;

  logic       d_stop, d_up_btn, d_down_btn, d_carry_in, d_borrow_in, d_load;
  logic [5:0] d_load_val, d_max_val, d_value;
  logic       d_carry_out, d_borrow_out;

  int compared;
  int mismatched;

  zaman_alani_sayaci #(
    .WIDTH(6), .MIN_VAL(0), .RESET_VAL(18), .REPEAT_DELAY(50), .REPEAT_RATE(10)
  ) u_hour (
    .clk(clk), .reset(reset), .stop(h_stop),
    .arttir_buton(h_up_btn), .azalt_buton(h_down_btn),
    .carry_in(h_carry_in), .borrow_in(h_borrow_in),
    .load(h_load), .load_val(h_load_val), .max_val(h_max_val),
    .value(h_value), .carry_out(h_carry_out), .borrow_out(h_borrow_out)
  );

  zaman_alani_sayaci #(
    .WIDTH(6), .MIN_VAL(1), .RESET_VAL(31), .REPEAT_DELAY(50), .REPEAT_RATE(10)
  ) u_day (
    .clk(clk), .reset(reset), .stop(d_stop),
    .arttir_buton(d_up_btn), .azalt_buton(d_down_btn),
    .carry_in(d_carry_in), .borrow_in(d_borrow_in),
    .load(d_load), .load_val(d_load_val), .max_val(d_max_val),
    .value(d_value), .carry_out(d_carry_out), .borrow_out(d_borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    h_stop = 0; h_up_btn = 0; h_down_btn = 0; h_carry_in = 0; h_borrow_in = 0;
    h_load = 0; h_load_val = 0; h_max_val = 6'd23;
    d_stop = 0; d_up_btn = 0; d_down_btn = 0; d_carry_in = 0; d_borrow_in = 0;
    d_load = 0; d_load_val = 0; d_max_val = 6'd31;
    tick();
    tick();
    compared++;
    if (h_value !== 6'd18) begin
      mismatched++; $display("[TB] FAIL reset_hour_value got %0d want 18", h_value);
    end
    compared++;
    if (h_carry_out !== 1'b0 || h_borrow_out !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_hour_pulses got c=%b b=%b want 0 0", h_carry_out, h_borrow_out);
    end
    compared++;
    if (d_value !== 6'd31) begin
      mismatched++; $display("[TB] FAIL reset_day_value got %0d want 31", d_value);
    end
    reset = 1'b0;
    tick();
    compared++;
    if (h_value !== 6'd18) begin
      mismatched++; $display("[TB] FAIL reset_release_hold got %0d want 18", h_value);
    end
  endtask

  task automatic test_carry_chain();
    int exp_v[6] = '{19, 20, 21, 22, 23, 0};
    for (int i = 0; i < 6; i++) begin
      h_carry_in = 1'b1;
      tick();
      h_carry_in = 1'b0;
      compared++;
      if (h_value !== exp_v[i][5:0]) begin
        mismatched++; $display("[TB] FAIL carry_chain_value[%0d] got %0d want %0d", i, h_value, exp_v[i]);
      end
      compared++;
      if (h_carry_out !== (i == 5) || h_borrow_out !== 1'b0) begin
        mismatched++; $display("[TB] FAIL carry_chain_pulse[%0d] got c=%b b=%b want c=%b b=0", i, h_carry_out, h_borrow_out, (i == 5));
      end
    end
    tick();
    compared++;
    if (h_carry_out !== 1'b0 || h_value !== 6'd0) begin
      mismatched++; $display("[TB] FAIL carry_pulse_width got c=%b v=%0d want c=0 v=0", h_carry_out, h_value);
    end
  endtask

  task automatic test_borrow_and_conflict();
    h_load = 1'b1; h_load_val = 6'd0;
    tick();
    h_load = 1'b0;
    compared++;
    if (h_value !== 6'd0 || h_carry_out !== 1'b0 || h_borrow_out !== 1'b0) begin
      mismatched++; $display("[TB] FAIL load_zero got v=%0d c=%b b=%b want 0 0 0", h_value, h_carry_out, h_borrow_out);
    end
    h_borrow_in = 1'b1;
    tick();
    h_borrow_in = 1'b0;
    compared++;
    if (h_value !== 6'd23 || h_borrow_out !== 1'b1 || h_carry_out !== 1'b0) begin
      mismatched++; $display("[TB] FAIL borrow_wrap got v=%0d c=%b b=%b want 23 0 1", h_value, h_carry_out, h_borrow_out);
    end
    tick();
    compared++;
    if (h_borrow_out !== 1'b0) begin
      mismatched++; $display("[TB] FAIL borrow_pulse_width got %b want 0", h_borrow_out);
    end
    h_carry_in = 1'b1; h_borrow_in = 1'b1;
    tick();
    h_carry_in = 1'b0; h_borrow_in = 1'b0;
    compared++;
    if (h_value !== 6'd23 || h_carry_out !== 1'b0 || h_borrow_out !== 1'b0) begin
      mismatched++; $display("[TB] FAIL carry_borrow_conflict got v=%0d c=%b b=%b want 23 0 0", h_value, h_carry_out, h_borrow_out);
    end
    h_load = 1'b1; h_load_val = 6'd40;
    tick();
    h_load = 1'b0;
    compared++;
    if (h_value !== 6'd23) begin
      mismatched++; $display("[TB] FAIL load_clamp_high got %0d want 23", h_value);
    end
  endtask

  task automatic test_button_hold();
    int exp_v;
    logic exp_c;
    h_load = 1'b1; h_load_val = 6'd18;
    tick();
    h_load = 1'b0;
    h_stop = 1'b1;
    tick();
    exp_v = 18;
    h_up_btn = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      h_carry_in = (c == 30 || c == 75);
      tick();
      h_carry_in = 1'b0;
      exp_c = 1'b0;
      if (c == 1 || c == 51 || c == 61 || c == 71 || c == 81 || c == 91) begin
        if (exp_v >= 23) begin
          exp_v = 0; exp_c = 1'b1;
        end else begin
          exp_v = exp_v + 1;
        end
      end
      compared++;
      if (h_value !== exp_v[5:0] || h_carry_out !== exp_c) begin
        mismatched++; $display("[TB] FAIL hold_cycle_%0d got v=%0d c=%b want v=%0d c=%b", c, h_value, h_carry_out, exp_v, exp_c);
      end
    end
    h_up_btn = 1'b0;
    for (int c = 0; c < 15; c++) tick();
    compared++;
    if (h_value !== 6'd0) begin
      mismatched++; $display("[TB] FAIL hold_final got %0d want 0", h_value);
    end
  endtask

  task automatic test_both_buttons();
    h_up_btn = 1'b1; h_down_btn = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    compared++;
    if (h_value !== 6'd0) begin
      mismatched++; $display("[TB] FAIL both_pressed got %0d want 0", h_value);
    end
    h_up_btn = 1'b0; h_down_btn = 1'b0;
    tick();
    h_down_btn = 1'b1;
    tick();
    compared++;
    if (h_value !== 6'd23 || h_borrow_out !== 1'b1) begin
      mismatched++; $display("[TB] FAIL down_after_both got v=%0d b=%b want 23 1", h_value, h_borrow_out);
    end
    for (int c = 0; c < 5; c++) tick();
    compared++;
    if (h_value !== 6'd23 || h_borrow_out !== 1'b0) begin
      mismatched++; $display("[TB] FAIL down_single_step got v=%0d b=%b want 23 0", h_value, h_borrow_out);
    end
    h_down_btn = 1'b0;
    tick();
  endtask

  task automatic test_variable_max();
    d_max_val = 6'd30;
    tick();
    compared++;
    if (d_value !== 6'd30 || d_carry_out !== 1'b0) begin
      mismatched++; $display("[TB] FAIL max_shrink got v=%0d c=%b want 30 0", d_value, d_carry_out);
    end
    d_load = 1'b1; d_load_val = 6'd0;
    tick();
    compared++;
    if (d_value !== 6'd1) begin
      mismatched++; $display("[TB] FAIL load_below_min got %0d want 1", d_value);
    end
    d_load_val = 6'd40;
    tick();
    d_load = 1'b0;
    compared++;
    if (d_value !== 6'd30) begin
      mismatched++; $display("[TB] FAIL load_above_max got %0d want 30", d_value);
    end
    d_carry_in = 1'b1;
    tick();
    d_carry_in = 1'b0;
    compared++;
    if (d_value !== 6'd1 || d_carry_out !== 1'b1) begin
      mismatched++; $display("[TB] FAIL day_wrap_up got v=%0d c=%b want 1 1", d_value, d_carry_out);
    end
    d_borrow_in = 1'b1;
    tick();
    d_borrow_in = 1'b0;
    compared++;
    if (d_value !== 6'd30 || d_borrow_out !== 1'b1 || d_carry_out !== 1'b0) begin
      mismatched++; $display("[TB] FAIL day_wrap_down got v=%0d c=%b b=%b want 30 0 1", d_value, d_carry_out, d_borrow_out);
    end
    d_max_val = 6'd28; d_carry_in = 1'b1;
    tick();
    d_carry_in = 1'b0;
    compared++;
    if (d_value !== 6'd28 || d_carry_out !== 1'b0 || d_borrow_out !== 1'b0) begin
      mismatched++; $display("[TB] FAIL clamp_drops_step got v=%0d c=%b b=%b want 28 0 0", d_value, d_carry_out, d_borrow_out);
    end
  endtask

  task automatic test_reset_mid_repeat();
    h_up_btn = 1'b1;
    for (int c = 0; c < 60; c++) tick();
    compared++;
    if (h_value !== 6'd1) begin
      mismatched++; $display("[TB] FAIL repeat_before_reset got %0d want 1", h_value);
    end
    reset = 1'b1;
    #2;
    compared++;
    if (h_value !== 6'd18) begin
      mismatched++; $display("[TB] FAIL async_reset got %0d want 18", h_value);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 80; c++) tick();
    compared++;
    if (h_value !== 6'd18) begin
      mismatched++; $display("[TB] FAIL held_through_reset got %0d want 18", h_value);
    end
    h_up_btn = 1'b0;
    tick();
    h_up_btn = 1'b1;
    tick();
    compared++;
    if (h_value !== 6'd19) begin
      mismatched++; $display("[TB] FAIL repress_after_reset got %0d want 19", h_value);
    end
    h_up_btn = 1'b0;
    tick();
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_carry_chain();
    test_borrow_and_conflict();
    test_button_hold();
    test_both_buttons();
    test_variable_max();
    test_reset_mid_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
